pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the toy processor. Drives the control inputs of the 8-bit lab counter (Count_in, Load, count, plus a clear) so that the counter walks through instruction addresses in a fetch/execute rhythm. Handles jumps, halts, end-of-program detection and single-step debugging. Counts retired instructions for the bench and the front-panel display.

## Interface
Parameters:
- LAST_ADDR, 8'hFF: final program address; a sequential retire at this address halts instead of incrementing.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level; in IDLE or HALT, begins a run from address 0.
- Stop  in  1  level; requests a halt at the next instruction boundary.
- Step_mode  in  1  level; 1 = pause after every instruction.
- Step  in  1  level; in PAUSE, releases one instruction.
- Jmp_req  in  1  decoder output; sampled only in EXEC.
- Jmp_addr  in  8  jump target; sampled with Jmp_req.
- Halt_req  in  1  decoder HALT opcode; sampled only in EXEC.
- Count_out  in  8  current counter value (instruction address).
- Count_in  out  8  load value to the counter (registered jump target).
- Load  out  1  counter parallel-load strobe.
- count  out  1  counter increment strobe.
- Clr  out  1  active-high synchronous clear to the counter.
- Fetch  out  1  instruction-memory read strobe.
- Phase  out  3  state encoding: IDLE=0, CLEAR=1, FETCH=2, EXEC=3, LOAD=4, PAUSE=5, HALT=6.
- Busy  out  1  1 in every state except IDLE and HALT.
- Halted  out  1  1 in HALT.
- Instr_cnt  out  CNT_W  retired instructions since the last Start; saturates at all-ones.

## Operation
- Moore FSM. Load, count, Clr, Fetch, Busy, Halted and Phase are decoded from the state register only.
- Count_in, Instr_cnt and stop_pend are registers.
- IDLE: all strobes 0. Start=1 -> CLEAR.
- CLEAR: Clr=1. Clear Instr_cnt and stop_pend. -> FETCH.
- FETCH: Fetch=1. -> EXEC.
- EXEC: retire one instruction and increment Instr_cnt unless it is all-ones. Next state by priority:
  1. Halt_req, Stop or stop_pend -> HALT.
  2. Jmp_req -> LOAD, with Count_in <= Jmp_addr.
  3. Count_out==LAST_ADDR -> HALT. No increment, so the counter never wraps 8'hFF -> 8'h00 under control of this block.
  4. Otherwise count=1 for this cycle, then -> PAUSE if Step_mode=1, else -> FETCH.
- The count strobe is the only Mealy exception: count=1 exactly in EXEC cycles that take branch 4.
- LOAD: Load=1. Count_in is stable for the whole cycle. -> PAUSE if Step_mode=1, else -> FETCH.
- PAUSE: all strobes 0.
  - Stop -> HALT.
  - Step=1 or Step_mode=0 -> FETCH.
  - Otherwise stay.
- HALT: Halted=1. Start=1 -> CLEAR. Otherwise stay. Instr_cnt holds.
- Stop in CLEAR, FETCH or LOAD sets stop_pend, so an instruction is never split. stop_pend is cleared in CLEAR.
- Simultaneous Jmp_req and Halt_req: halt wins, and Count_in is unchanged.
- Jmp_addr==LAST_ADDR is a legal jump. That instruction then halts at its sequential retire.

## Timing
- Reset (asynchronous assert, released synchronously by the environment) forces:
  - state IDLE, Phase=0;
  - Count_in=8'h00, Instr_cnt=0, stop_pend=0;
  - Load, count, Clr, Fetch, Busy and Halted all 0.
- Reset mid-run behaves identically and aborts immediately. The counter's own state is not touched by this block.
- Start sampled high at edge N: CLEAR during cycle N+1, first FETCH during N+2, first EXEC during N+3.
- Sequential instruction: 2 cycles (FETCH, EXEC). Counter advances on the edge ending EXEC.
- Jump instruction: 3 cycles (FETCH, EXEC, LOAD). Counter holds Jmp_addr after the edge ending LOAD.
- Halt latency: HALT is entered on the edge ending the EXEC in which the halt condition is seen.
- Step is level-sensitive. Holding Step=1 in step mode gives 3 cycles per instruction (FETCH, EXEC, PAUSE).

## Test plan
- Reset, then Start pulse with no jumps and LAST_ADDR=8'h07 -> Clr for one cycle; Count_out runs 0..7; HALT entered after the EXEC at 7; Instr_cnt=8; count pulses=7.
- Jump: in the EXEC at address 3, Jmp_req=1 with Jmp_addr=8'hFB -> LOAD cycle with Load=1 and Count_in=8'hFB; next FETCH at 8'hFB; Instr_cnt counts the jump once.
- Simultaneous Jmp_req=1, Jmp_addr=8'h40 and Halt_req=1 -> HALT; Count_in unchanged; no Load pulse.
- Stop asserted during FETCH at address 5 -> instruction 5 retires; HALT follows with no count pulse; Start from HALT -> CLEAR and Instr_cnt=0.
- Step_mode=1, Step held 0 -> PAUSE after each EXEC, 0 Fetch pulses while waiting; one-cycle Step pulse -> exactly one more FETCH/EXEC pair.
- Reset asserted mid-EXEC -> all outputs 0 and Phase=0 immediately (asynchronously), before the next CLK edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Purpose:
//   Program-counter sequencer for the toy processor. Drives the 8-bit lab
//   counter (Count_in/Load/count/Clr) so it walks through instruction
//   addresses in a fetch/execute rhythm. Supports jumps, halts, end-of-program
//   detection, single-step debugging and counts retired instructions.
//
// Ports:
//   CLK        system clock, rising edge
//   Reset      asynchronous active-low reset
//   Start      level, begins a run from address 0 when in IDLE or HALT
//   Stop       level, halt at the next instruction boundary
//   Step_mode  level, 1 = pause after every instruction
//   Step       level, releases one instruction while in PAUSE
//   Jmp_req    decoder jump request, sampled in EXEC
//   Jmp_addr   jump target, sampled with Jmp_req
//   Halt_req   decoder HALT opcode, sampled in EXEC
//   Count_out  current counter value (instruction address)
//   Count_in   registered jump target for the counter load
//   Load       counter parallel-load strobe
//   count      counter increment strobe
//   Clr        counter synchronous clear
//   Fetch      instruction-memory read strobe
//   Phase      state encoding
//   Busy       1 in every state except IDLE and HALT
//   Halted     1 in HALT
//   Instr_cnt  retired instructions since the last Start, saturating
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for Start
// CLEAR | clear counter, retire count and pending stop
// FETCH | instruction-memory read
// EXEC  | retire instruction, choose halt / jump / increment
// LOAD  | counter loads the registered jump target
// PAUSE | single-step wait between instructions
// HALT  | stopped, waiting for Start

module pc_sequencer #(
    parameter logic [7:0] LAST_ADDR = 8'hFF,
    parameter int         CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Step_mode,
    input  logic             Step,
    input  logic             Jmp_req,
    input  logic [7:0]       Jmp_addr,
    input  logic             Halt_req,
    input  logic [7:0]       Count_out,
    output logic [7:0]       Count_in,
    output logic             Load,
    output logic             count,
    output logic             Clr,
    output logic             Fetch,
    output logic [2:0]       Phase,
    output logic             Busy,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       stop_pend;
    logic       halt_hit;
    logic       at_last;

    // Halt has priority over a jump in the same EXEC.
    assign halt_hit = Halt_req | Stop | stop_pend;
    assign at_last  = (Count_out == LAST_ADDR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (halt_hit)
                    state_nxt = S_HALT;
                else if (Jmp_req)
                    state_nxt = S_LOAD;
                else if (at_last)
                    state_nxt = S_HALT;
                else if (Step_mode)
                    state_nxt = S_PAUSE;
                else
                    state_nxt = S_FETCH;
            end
            S_LOAD:  state_nxt = Step_mode ? S_PAUSE : S_FETCH;
            S_PAUSE: begin
                if (Stop)
                    state_nxt = S_HALT;
                else if (Step || !Step_mode)
                    state_nxt = S_FETCH;
            end
            S_HALT:  if (Start) state_nxt = S_CLEAR;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Phase  = state;
    assign Clr    = (state == S_CLEAR);
    assign Fetch  = (state == S_FETCH);
    assign Load   = (state == S_LOAD);
    assign Halted = (state == S_HALT);
    assign Busy   = (state != S_IDLE) && (state != S_HALT);

    // Only Mealy output: increment only on a plain sequential retire, so the
    // counter never wraps past LAST_ADDR under our control.
    assign count  = (state == S_EXEC) && !halt_hit && !Jmp_req && !at_last;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
            Count_in  <= 8'h00;
            Instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_CLEAR: begin
                    Instr_cnt <= '0;
                    // A Stop seen while clearing still has to take effect.
                    stop_pend <= Stop;
                end
                S_FETCH, S_LOAD: begin
                    if (Stop)
                        stop_pend <= 1'b1;
                end
                S_EXEC: begin
                    if (Instr_cnt != '1)
                        Instr_cnt <= Instr_cnt + CNT_W'(1);
                    if (!halt_hit && Jmp_req)
                        Count_in <= Jmp_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0, Stop = 1'b0, Step_mode = 1'b0, Step = 1'b0;
    logic        Jmp_req = 1'b0, Halt_req = 1'b0;
    logic [7:0]  Jmp_addr = 8'h00;
    logic [7:0]  Count_out;
    logic [7:0]  Count_in;
    logic        Load, count, Clr, Fetch, Busy, Halted;
    logic [2:0]  Phase;
    logic [15:0] Instr_cnt;

    // second instance: tiny saturating counter, no end-of-program in range
    logic [7:0]  Count_out2;
    logic [7:0]  Count_in2;
    logic        Load2, count2, Clr2, Fetch2, Busy2, Halted2;
    logic [2:0]  Phase2;
    logic [1:0]  Instr_cnt2;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.LAST_ADDR(8'h07), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop),
        .Step_mode(Step_mode), .Step(Step), .Jmp_req(Jmp_req),
        .Jmp_addr(Jmp_addr), .Halt_req(Halt_req), .Count_out(Count_out),
        .Count_in(Count_in), .Load(Load), .count(count), .Clr(Clr),
        .Fetch(Fetch), .Phase(Phase), .Busy(Busy), .Halted(Halted),
        .Instr_cnt(Instr_cnt)
    );

    pc_sequencer #(.LAST_ADDR(8'hFF), .CNT_W(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop),
        .Step_mode(Step_mode), .Step(Step), .Jmp_req(Jmp_req),
        .Jmp_addr(Jmp_addr), .Halt_req(Halt_req), .Count_out(Count_out2),
        .Count_in(Count_in2), .Load(Load2), .count(count2), .Clr(Clr2),
        .Fetch(Fetch2), .Phase(Phase2), .Busy(Busy2), .Halted(Halted2),
        .Instr_cnt(Instr_cnt2)
    );

    // behavioural model of the 8-bit lab counter
    always @(posedge CLK or negedge Reset) begin
        if (!Reset)     Count_out <= 8'h00;
        else if (Clr)   Count_out <= 8'h00;
        else if (Load)  Count_out <= Count_in;
        else if (count) Count_out <= Count_out + 8'd1;
    end

    always @(posedge CLK or negedge Reset) begin
        if (!Reset)      Count_out2 <= 8'h00;
        else if (Clr2)   Count_out2 <= 8'h00;
        else if (Load2)  Count_out2 <= Count_in2;
        else if (count2) Count_out2 <= Count_out2 + 8'd1;
    end

    always @(posedge CLK) if (count) pulses <= pulses + 1;

    typedef struct {
        logic        start, stop, smode, step, jmp, halt;
        logic [7:0]  jaddr;
        logic [2:0]  ph;
        logic        ld, cn, cl, fe;
        logic [7:0]  cin;
        logic [15:0] ins;
        logic [7:0]  ad;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic start, stop, smode, step, jmp, halt,
                        input logic [7:0] jaddr, input logic [2:0] ph,
                        input logic ld, cn, cl, fe, input logic [7:0] cin,
                        input logic [15:0] ins, input logic [7:0] ad);
        vec_t v;
        v.start = start; v.stop = stop; v.smode = smode; v.step = step;
        v.jmp = jmp; v.halt = halt; v.jaddr = jaddr; v.ph = ph;
        v.ld = ld; v.cn = cn; v.cl = cl; v.fe = fe;
        v.cin = cin; v.ins = ins; v.ad = ad;
        tbl.push_back(v);
    endtask

    // plain sequential instruction: FETCH then EXEC
    task automatic seq_instr(input logic [7:0] a, input logic [15:0] ins,
                             input logic [7:0] cin, input logic smode,
                             input logic cn);
        push(0,0,smode,0,0,0,8'h00, 3'd2, 0,0,0,1, cin, ins, a);
        push(0,0,smode,0,0,0,8'h00, 3'd3, 0,cn,0,0, cin, ins, a);
    endtask

    task automatic chk(input int idx, input string name,
                       input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_err++;
            $display("FAIL vec %0d %s: got %0h want %0h", idx, name, got, want);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            Start = tbl[i].start; Stop = tbl[i].stop; Step_mode = tbl[i].smode;
            Step = tbl[i].step; Jmp_req = tbl[i].jmp; Halt_req = tbl[i].halt;
            Jmp_addr = tbl[i].jaddr;
            #1;
            n_vec++;
            chk(n_vec, "phase",    32'(Phase),     32'(tbl[i].ph));
            chk(n_vec, "load",     32'(Load),      32'(tbl[i].ld));
            chk(n_vec, "count",    32'(count),     32'(tbl[i].cn));
            chk(n_vec, "clr",      32'(Clr),       32'(tbl[i].cl));
            chk(n_vec, "fetch",    32'(Fetch),     32'(tbl[i].fe));
            chk(n_vec, "busy",     32'(Busy),      32'(tbl[i].ph != 3'd0 && tbl[i].ph != 3'd6));
            chk(n_vec, "halted",   32'(Halted),    32'(tbl[i].ph == 3'd6));
            chk(n_vec, "count_in", 32'(Count_in),  32'(tbl[i].cin));
            chk(n_vec, "instr",    32'(Instr_cnt), 32'(tbl[i].ins));
            chk(n_vec, "addr",     32'(Count_out), 32'(tbl[i].ad));
            @(negedge CLK);
        end
        tbl.delete();
    endtask

    task automatic hand(input string name, input logic [31:0] got,
                        input logic [31:0] want);
        n_vec++;
        chk(n_vec, name, got, want);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        Reset = 1'b1;

        // reset state, then full sequential run 0..7
        push(1,0,0,0,0,0,8'h00, 3'd0, 0,0,0,0, 8'h00, 16'd0, 8'h00);
        push(0,0,0,0,0,0,8'h00, 3'd1, 0,0,1,0, 8'h00, 16'd0, 8'h00);
        for (int a = 0; a < 8; a++)
            seq_instr(8'(a), 16'(a), 8'h00, 1'b0, a != 7);
        push(0,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'h00, 16'd8, 8'h07);
        run_table();
        hand("count_pulses", 32'(pulses), 32'd7);
        hand("sat_instr_cnt", 32'(Instr_cnt2), 32'd3);

        // jump at address 3 to 8'hFB, then halt opcode there
        push(1,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'h00, 16'd8, 8'h07);
        push(0,0,0,0,0,0,8'h00, 3'd1, 0,0,1,0, 8'h00, 16'd8, 8'h07);
        for (int a = 0; a < 3; a++)
            seq_instr(8'(a), 16'(a), 8'h00, 1'b0, 1'b1);
        push(0,0,0,0,0,0,8'h00, 3'd2, 0,0,0,1, 8'h00, 16'd3, 8'h03);
        push(0,0,0,0,1,0,8'hFB, 3'd3, 0,0,0,0, 8'h00, 16'd3, 8'h03);
        push(0,0,0,0,0,0,8'h00, 3'd4, 1,0,0,0, 8'hFB, 16'd4, 8'h03);
        push(0,0,0,0,0,0,8'h00, 3'd2, 0,0,0,1, 8'hFB, 16'd4, 8'hFB);
        push(0,0,0,0,0,1,8'h00, 3'd3, 0,0,0,0, 8'hFB, 16'd4, 8'hFB);
        push(0,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd5, 8'hFB);

        // simultaneous jump and halt: halt wins, Count_in untouched
        push(1,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd5, 8'hFB);
        push(0,0,0,0,0,0,8'h00, 3'd1, 0,0,1,0, 8'hFB, 16'd5, 8'hFB);
        push(0,0,0,0,0,0,8'h00, 3'd2, 0,0,0,1, 8'hFB, 16'd0, 8'h00);
        push(0,0,0,0,1,1,8'h40, 3'd3, 0,0,0,0, 8'hFB, 16'd0, 8'h00);
        push(0,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd1, 8'h00);
        push(0,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd1, 8'h00);

        // Stop during FETCH at 5: instruction 5 retires, then HALT
        push(1,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd1, 8'h00);
        push(0,0,0,0,0,0,8'h00, 3'd1, 0,0,1,0, 8'hFB, 16'd1, 8'h00);
        for (int a = 0; a < 5; a++)
            seq_instr(8'(a), 16'(a), 8'hFB, 1'b0, 1'b1);
        push(0,1,0,0,0,0,8'h00, 3'd2, 0,0,0,1, 8'hFB, 16'd5, 8'h05);
        push(0,0,0,0,0,0,8'h00, 3'd3, 0,0,0,0, 8'hFB, 16'd5, 8'h05);
        push(0,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd6, 8'h05);
        push(1,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd6, 8'h05);
        push(0,0,0,0,0,0,8'h00, 3'd1, 0,0,1,0, 8'hFB, 16'd6, 8'h05);
        push(0,0,1,0,0,0,8'h00, 3'd2, 0,0,0,1, 8'hFB, 16'd0, 8'h00);

        // single step: wait in PAUSE, one Step pulse gives one instruction
        push(0,0,1,0,0,0,8'h00, 3'd3, 0,1,0,0, 8'hFB, 16'd0, 8'h00);
        for (int k = 0; k < 3; k++)
            push(0,0,1,0,0,0,8'h00, 3'd5, 0,0,0,0, 8'hFB, 16'd1, 8'h01);
        push(0,0,1,1,0,0,8'h00, 3'd5, 0,0,0,0, 8'hFB, 16'd1, 8'h01);
        push(0,0,1,0,0,0,8'h00, 3'd2, 0,0,0,1, 8'hFB, 16'd1, 8'h01);
        push(0,0,1,0,0,0,8'h00, 3'd3, 0,1,0,0, 8'hFB, 16'd1, 8'h01);
        push(0,0,1,0,0,0,8'h00, 3'd5, 0,0,0,0, 8'hFB, 16'd2, 8'h02);
        push(0,0,1,0,0,0,8'h00, 3'd5, 0,0,0,0, 8'hFB, 16'd2, 8'h02);
        push(0,1,1,0,0,0,8'h00, 3'd5, 0,0,0,0, 8'hFB, 16'd2, 8'h02);
        push(0,0,0,0,0,0,8'h00, 3'd6, 0,0,0,0, 8'hFB, 16'd2, 8'h02);
        run_table();

        // asynchronous reset in the middle of an EXEC
        Start = 1'b1;
        @(negedge CLK); Start = 1'b0;       // CLEAR
        repeat (4) @(negedge CLK);          // FETCH0 EXEC0 FETCH1 EXEC1
        #1;
        hand("pre_rst_phase", 32'(Phase), 32'd3);
        hand("pre_rst_instr", 32'(Instr_cnt), 32'd1);
        Reset = 1'b0;
        #1;
        hand("rst_phase",    32'(Phase),     32'd0);
        hand("rst_strobes",  32'({Load, count, Clr, Fetch, Busy, Halted}), 32'd0);
        hand("rst_count_in", 32'(Count_in),  32'd0);
        hand("rst_instr",    32'(Instr_cnt), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        #1;
        hand("post_rst_idle", 32'(Phase), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
